// File: rtl/pe_pkg.sv
// Shared constants for the dot4_relu_pe datapath.
//   DW      activation / weight / result width
//   PW      full-precision product width
//   SW      exact sum-of-four-products width
//   OUT_LSB / OUT_MSB  slice of the sum presented on the result
package pe_pkg;
  localparam int unsigned DW      = 5;
  localparam int unsigned PW      = 10;
  localparam int unsigned SW      = 12;
  localparam int unsigned OUT_LSB = 3;
  localparam int unsigned OUT_MSB = 6;
endpackage

// File: rtl/MUX2x1.sv
// Two-input multiplexer of width W.
//   in0  selected when sel = 0
//   in1  selected when sel = 1
//   out  selected input
module MUX2x1 #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/adder.sv
// Signed adder with one bit of growth so the sum can never overflow.
//   a, b  signed W-bit operands
//   s     signed (W+1)-bit sum
module adder #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   s
);

  assign s = {a[W-1], a} + {b[W-1], b};

endmodule

// File: rtl/multiplier.sv
// Combinational signed DW x DW -> PW multiplier, full precision.
//   A, B  signed operands
//   out   signed product
module multiplier
  import pe_pkg::*;
(
  input  logic signed [DW-1:0] A,
  input  logic signed [DW-1:0] B,
  output logic signed [PW-1:0] out
);

  // Both operands are signed, so they are sign-extended to PW before the multiply.
  assign out = A * B;

endmodule

// File: rtl/registerBlock.sv
// Bank of WORDS registers of width W with a common load enable.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low clear of every word
//   en     load all words from d when high, hold otherwise
//   d      next values
//   q      stored values
module registerBlock #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned W     = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [WORDS-1:0][W-1:0]   d,
  output logic [WORDS-1:0][W-1:0]   q
);

  logic [WORDS-1:0][W-1:0] words_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
    end else if (en) begin
      words_q <= d;
    end
  end

  assign q = words_q;

endmodule

// File: rtl/dot4_relu_pe.sv
// Four-pair signed dot product with a registered product stage and a
// ReLU-gated, rescaled 5-bit output.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset, clears the product registers
//   enReg      product-register load enable
//   A1..A4     signed activations
//   W1..W4     signed weights
//   result     0 for a negative sum, else {0, sum[OUT_MSB:OUT_LSB]}
module dot4_relu_pe
  import pe_pkg::*;
#(
  parameter int unsigned DW_P = DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enReg,
  input  logic [DW_P-1:0] A1,
  input  logic [DW_P-1:0] A2,
  input  logic [DW_P-1:0] A3,
  input  logic [DW_P-1:0] A4,
  input  logic [DW_P-1:0] W1,
  input  logic [DW_P-1:0] W2,
  input  logic [DW_P-1:0] W3,
  input  logic [DW_P-1:0] W4,
  output logic [DW_P-1:0] result
);

  logic [3:0][PW-1:0] prod_d;
  logic [3:0][PW-1:0] prod_q;
  logic [PW:0]        s12;
  logic [PW:0]        s34;
  logic [SW-1:0]      sum;
  logic               sign;
  logic               sum_unused;

  multiplier u_mul1 (.A(A1), .B(W1), .out(prod_d[0]));
  multiplier u_mul2 (.A(A2), .B(W2), .out(prod_d[1]));
  multiplier u_mul3 (.A(A3), .B(W3), .out(prod_d[2]));
  multiplier u_mul4 (.A(A4), .B(W4), .out(prod_d[3]));

  registerBlock #(.WORDS(4), .W(PW)) u_prod_regs (
    .clk  (clk),
    .rst_n(rst),
    .en   (enReg),
    .d    (prod_d),
    .q    (prod_q)
  );

  adder #(.W(PW))   u_add12 (.a(prod_q[0]), .b(prod_q[1]), .s(s12));
  adder #(.W(PW))   u_add34 (.a(prod_q[2]), .b(prod_q[3]), .s(s34));
  adder #(.W(PW+1)) u_addt  (.a(s12),       .b(s34),       .s(sum));

  assign sign = sum[SW-1];

  // Non-negative sums beyond the output slice wrap: the high bits are dropped.
  assign sum_unused = ^{sum[SW-2:OUT_MSB+1], sum[OUT_LSB-1:0]};

  MUX2x1 #(.W(DW_P)) u_relu (
    .in0(DW_P'({sign, sum[OUT_MSB:OUT_LSB]})),
    .in1('0),
    .sel(sign),
    .out(result)
  );

endmodule

// File: tb/tb_dot4_relu_pe.sv
module tb_dot4_relu_pe;

  logic       clk;
  logic       rst;
  logic       enReg;
  logic [4:0] A1, A2, A3, A4, W1, W2, W3, W4;
  logic [4:0] result;

  logic signed [4:0] ma, mb;
  logic signed [9:0] mp;
  logic [4:0]        mi0, mi1, mo;
  logic              msel;

  int total = 0;
  int bad   = 0;
  int av[4];
  int wv[4];

  dot4_relu_pe #(.DW_P(5)) dut (
    .clk(clk), .rst(rst), .enReg(enReg),
    .A1(A1), .A2(A2), .A3(A3), .A4(A4),
    .W1(W1), .W2(W2), .W3(W3), .W4(W4),
    .result(result)
  );

  multiplier u_mul (.A(ma), .B(mb), .out(mp));
  MUX2x1 #(.W(5)) u_mux (.in0(mi0), .in1(mi1), .sel(msel), .out(mo));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer dot product, ReLU, then bits 6..3 of the sum.
  function automatic logic [4:0] model();
    int s = 0;
    for (int i = 0; i < 4; i++) s += av[i] * wv[i];
    if (s < 0) return 5'd0;
    return 5'((s / 8) % 16);
  endfunction

  function automatic int rnd5();
    return int'($urandom_range(0, 31)) - 16;
  endfunction

  task automatic put_inputs();
    A1 = 5'(av[0]); A2 = 5'(av[1]); A3 = 5'(av[2]); A4 = 5'(av[3]);
    W1 = 5'(wv[0]); W2 = 5'(wv[1]); W3 = 5'(wv[2]); W4 = 5'(wv[3]);
  endtask

  // Apply operands at the falling edge, clock once, sample 1 time unit later.
  task automatic drive(input logic en);
    @(negedge clk);
    put_inputs();
    enReg = en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    av = '{7, 3, -5, 2}; wv = '{7, 6, 1, -9};
    put_inputs();
    #3;
    total++;
    if (result !== 5'd0) begin bad++; $display("FAIL reset_initial got=%0d want=0", result); end
    @(negedge clk);
    rst = 1'b1;
    enReg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (result !== 5'd0) begin bad++; $display("FAIL reset_no_en got=%0d want=0", result); end
    av = '{7, 0, 0, 0}; wv = '{7, 0, 0, 0};
    drive(1'b1);
    total++;
    if (result !== 5'd6) begin bad++; $display("FAIL reset_preload got=%0d want=6", result); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (result !== 5'd0) begin bad++; $display("FAIL reset_async got=%0d want=0", result); end
    @(posedge clk);
    #1;
    total++;
    if (result !== 5'd0) begin bad++; $display("FAIL reset_priority got=%0d want=0", result); end
    @(negedge clk);
    rst = 1'b1;
    enReg = 1'b0;
  endtask

  task automatic test_scaling();
    av = '{8, 0, 0, 0}; wv = '{1, 0, 0, 0};
    drive(1'b1);
    total++;
    if (result !== 5'd1) begin bad++; $display("FAIL scale_8x1 got=%0d want=1", result); end
    av = '{7, 0, 0, 0}; wv = '{7, 0, 0, 0};
    drive(1'b1);
    total++;
    if (result !== 5'd6) begin bad++; $display("FAIL scale_7x7 got=%0d want=6", result); end
    av = '{0, 0, 0, 0}; wv = '{5, -3, 2, 1};
    drive(1'b1);
    total++;
    if (result !== 5'd0) begin bad++; $display("FAIL scale_zero got=%0d want=0", result); end
  endtask

  task automatic test_truncation();
    av = '{7, 7, 7, 7}; wv = '{7, 7, 7, 7};
    drive(1'b1);
    total++;
    if (result !== 5'd8) begin bad++; $display("FAIL trunc_196 got=%0d want=8", result); end
    av = '{-16, -16, -16, -16}; wv = '{-16, -16, -16, -16};
    drive(1'b1);
    total++;
    if (result !== 5'd0) begin bad++; $display("FAIL trunc_1024 got=%0d want=0", result); end
  endtask

  task automatic test_relu();
    av = '{-16, 0, 0, 0}; wv = '{15, 0, 0, 0};
    drive(1'b1);
    total++;
    if (result !== 5'd0) begin bad++; $display("FAIL relu_m240 got=%0d want=0", result); end
    av = '{8, -1, 0, 0}; wv = '{1, 1, 0, 0};
    drive(1'b1);
    total++;
    if (result !== 5'd0) begin bad++; $display("FAIL relu_sum7 got=%0d want=0", result); end
    av = '{8, -8, 0, 0}; wv = '{2, 1, 0, 0};
    drive(1'b1);
    total++;
    if (result !== 5'd1) begin bad++; $display("FAIL relu_sum8 got=%0d want=1", result); end
    av = '{-1, 0, 0, 0}; wv = '{1, 0, 0, 0};
    drive(1'b1);
    total++;
    if (result !== 5'd0) begin bad++; $display("FAIL relu_m1 got=%0d want=0", result); end
  endtask

  task automatic test_hold();
    logic [4:0] exp;
    av = '{7, 0, 0, 0}; wv = '{7, 0, 0, 0};
    drive(1'b1);
    total++;
    if (result !== 5'd6) begin bad++; $display("FAIL hold_load got=%0d want=6", result); end
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++) begin av[i] = rnd5(); wv[i] = rnd5(); end
      av[0] = 15; wv[0] = 15;
      drive(1'b0);
      total++;
      if (result !== 5'd6) begin bad++; $display("FAIL hold_cycle%0d got=%0d want=6", c, result); end
    end
    exp = model();
    drive(1'b1);
    total++;
    if (result !== exp) begin bad++; $display("FAIL hold_release got=%0d want=%0d", result, exp); end
  endtask

  task automatic test_random();
    logic [4:0] exp;
    logic       en;
    exp = result;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin av[i] = rnd5(); wv[i] = rnd5(); end
      en = (n < 100) ? 1'b1 : 1'($urandom_range(0, 1));
      if (en) exp = model();
      drive(en);
      total++;
      if (result !== exp) begin
        bad++;
        $display("FAIL random_%0d en=%0b got=%0d want=%0d", n, en, result, exp);
      end
    end
  endtask

  task automatic test_multiplier();
    int sa, sb;
    logic [9:0] exp;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        sa = (i >= 16) ? i - 32 : i;
        sb = (j >= 16) ? j - 32 : j;
        ma = 5'(i);
        mb = 5'(j);
        exp = 10'(sa * sb);
        #1;
        total++;
        if (mp !== exp) begin
          bad++;
          $display("FAIL mult_%0d_%0d got=%0d want=%0d", sa, sb, $signed(mp), sa * sb);
        end
      end
    end
  endtask

  task automatic test_mux();
    logic [4:0] x, y;
    for (int n = 0; n < 8; n++) begin
      x = 5'($urandom_range(0, 31));
      y = ~x;
      mi0 = x; mi1 = y;
      msel = 1'b0;
      #1;
      total++;
      if (mo !== x) begin bad++; $display("FAIL mux_sel0 got=%0d want=%0d", mo, x); end
      msel = 1'b1;
      #1;
      total++;
      if (mo !== y) begin bad++; $display("FAIL mux_sel1 got=%0d want=%0d", mo, y); end
    end
  endtask

  initial begin
    rst = 1'b0;
    enReg = 1'b1;
    ma = '0; mb = '0; mi0 = '0; mi1 = '0; msel = 1'b0;
    test_reset();
    test_scaling();
    test_truncation();
    test_relu();
    test_hold();
    test_random();
    test_multiplier();
    test_mux();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot4_relu_pe.md
# dot4_relu_pe

Four-input signed dot-product processing element with a ReLU-style output stage, used as the per-neuron compute unit of the network datapath. It multiplies four 5-bit activation/weight pairs, captures the products in an enable-gated pipeline register, sums them exactly, and emits a 5-bit rescaled, non-negative result. It is built from four `multiplier` instances and one `MUX2x1` instance; these two sub-modules are the units under test.

## Interface
Parameters:
- `DW`, 5: activation/weight/result width; fixed at 5 for this block.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enReg`  in  1  product-register load enable.
- `A1`..`A4`  in  5 each  activations, two's complement.
- `W1`..`W4`  in  5 each  weights, two's complement.
- `result`  out  5  ReLU-gated, rescaled dot product.

## Operation
- `multiplier`: combinational, `out[9:0] = A * B`.
  - A, B: signed 5-bit.
  - Full-precision signed 10-bit product, no truncation.
  - Range is −240 to +256.
- Product registers: four 10-bit registers.
  - Load all four products when `enReg`=1 at a rising `clk` edge.
  - Hold their value when `enReg`=0.
- Adder tree: combinational, from the registered products, no overflow possible.
  - `s12 = p1 + p2` and `s34 = p3 + p4`, each 11-bit sign-extended.
  - `sum = s12 + s34`, 12-bit sign-extended.
- `sign = sum[11]`.
- `MUX2x1`: 5-bit, `out = sel ? in1 : in0`.
  - Instantiated with `in0 = {sign, sum[6:3]}`, `in1 = 5'b0`, `sel = sign`.
- Resulting `result`:
  - Negative sum: `5'b00000`.
  - Otherwise: `{1'b0, sum[6:3]}`.
- Non-negative sums with any of bits 10..7 set are not saturated. The upper bits are discarded, giving modular truncation by design.
- Zero sum gives 0.

## Timing
- Async reset (`rst`=0): all product registers clear to 0 immediately, so `result`=0 immediately.
- After reset deassertion, registers load on the first rising edge with `enReg`=1.
- Latency is 1 cycle. Inputs sampled at edge N with `enReg`=1 appear on `result` after edge N, settled combinationally within that cycle.
- `result` is a pure combinational function of the product registers and is glitch-tolerant only after the combinational settle.
- If `enReg`=0, `result` is held indefinitely regardless of input changes.
- Reset asserted mid-operation: the outputs clear regardless of `enReg`. Reset has priority.
- Throughput is one new operand set per cycle when `enReg` is held at 1.

## Structure
- Shared package `pe_pkg`:
  - `DW=5`, `PW=10` (product), `SW=12` (sum).
  - Output slice constants `OUT_LSB=3`, `OUT_MSB=6`.
- Sub-modules:
  - `multiplier`: signed 5×5→10, combinational, ×4.
  - `MUX2x1`: parameterizable width, default 5, ×1.
- Product register bank: a small `registerBlock`-style module with 4 words, width parameter, async active-low clear, and load enable.
- Adders: inline, or one width-parameterized `adder` module with a sign-extending (width+1) output.

## Test plan
- Reset: drive `rst`=0 with any inputs → `result`=0 with no clock edge; release, no `enReg` → stays 0.
- Basic scaling: A1=8, W1=1, others 0, `enReg`=1, one edge → sum=8, `result`=1.
  - Same with A1=7, W1=7 → sum=49, `result`=6.
- Truncation: all pairs 7×7, one edge → sum=196, `result`=8 (bit 7 dropped).
  - All pairs −16×−16 → sum=1024, `result`=0.
- Negative/ReLU: A1=−16, W1=15, others 0 → sum=−240, `result`=0.
  - A1=8, W1=1 and A2=−1, W2=1 → sum=7, `result`=0.
  - A1=8, W1=2 and A2=−8, W2=1 → sum=8, `result`=1.
- Hold: load 7×7 (`result`=6), set `enReg`=0, change all inputs for 3 cycles → `result` stays 6.
  - Then `enReg`=1 → `result` follows the new inputs next cycle.
- Sub-module checks:
  - `multiplier` exhaustive over 1024 A/B pairs against the signed reference product.
  - `MUX2x1`: `sel`=0 passes `in0`, `sel`=1 passes `in1`.
